// File: rtl/sdram_cmd_queue_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sdram_cmd_queue_pkg : FSM encoding and entry sizing (rev 1.0)              |
// +----------------------------------------------------------------------------+
package sdram_cmd_queue_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_e;

  // Queue entry layout is {is_read, addr, data}.
  function automatic int entry_width(input int haddr_w, input int data_w);
    return 1 + haddr_w + data_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_cmd_queue_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sdram_cmd_queue_sync_fifo : single-clock FIFO, registered level/full (rev 1.0) |
// +----------------------------------------------------------------------------+
module sdram_cmd_queue_sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      din_i,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      dout_o,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int                  DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LVL_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  full_q, full_d;
  logic                  push_ok, pop_ok;

  // Acceptance is decided on start-of-cycle state only; no pop bypass.
  assign push_ok = push_i & ~full_q;
  assign pop_ok  = pop_i & (level_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (push_ok && !pop_ok)      level_d = level_q + LVL_ONE;
    else if (!push_ok && pop_ok) level_d = level_q - LVL_ONE;
    full_d = (level_d == LVL_FULL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;
  assign full_o  = full_q;
  assign empty_o = (level_q == '0);

endmodule
`default_nettype wire

// File: rtl/sdram_cmd_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sdram_cmd_queue : queues host read/write pulses for the SDRAM ctrl (rev 1.0) |
// +----------------------------------------------------------------------------+
module sdram_cmd_queue
  import sdram_cmd_queue_pkg::*;
#(
  parameter int HADDR_WIDTH = 24,
  parameter int DATA_WIDTH  = 16,
  parameter int DEPTH_LOG2  = 2,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [HADDR_WIDTH-1:0] h_haddr,
  input  logic [DATA_WIDTH-1:0]  h_wdata,
  input  logic                   h_rd_enable,
  input  logic                   h_wr_enable,
  output logic                   h_full,
  output logic [DATA_WIDTH-1:0]  h_rdata,
  output logic                   h_rvalid,
  output logic [DEPTH_LOG2:0]    level,
  output logic                   overflow,
  output logic                   timeout,
  output logic [HADDR_WIDTH-1:0] c_haddr,
  output logic [DATA_WIDTH-1:0]  c_wdata,
  output logic                   c_rd_enable,
  output logic                   c_wr_enable,
  input  logic                   c_busy,
  input  logic [DATA_WIDTH-1:0]  c_rdata
);

  localparam int               ENTRY_W  = entry_width(HADDR_WIDTH, DATA_WIDTH);
  localparam int               CNT_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [ENTRY_W-1:0]   cmd_q, cmd_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 timeout_q, timeout_d;
  logic                 overflow_q, overflow_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                 rvalid_q, rvalid_d;

  logic                 req;
  logic [ENTRY_W-1:0]   entry;
  logic                 pop;
  logic [ENTRY_W-1:0]   fifo_dout;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 cmd_is_read;

  // A simultaneous read+write keeps the write; the read is reported as dropped.
  assign req   = h_wr_enable | h_rd_enable;
  assign entry = h_wr_enable ? {1'b0, h_haddr, h_wdata}
                             : {1'b1, h_haddr, {DATA_WIDTH{1'b0}}};

  assign overflow_d = overflow_q | (h_wr_enable & h_rd_enable) | (req & fifo_full);

  sdram_cmd_queue_sync_fifo #(
    .WIDTH      (ENTRY_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (req),
    .din_i   (entry),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .level_o (level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign cmd_is_read = cmd_q[ENTRY_W-1];

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    rdata_d   = rdata_q;
    rvalid_d  = 1'b0;
    pop       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && !c_busy) begin
          pop     = 1'b1;
          cmd_d   = fifo_dout;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (c_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == ACK_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_WAIT_DONE: begin
        if (!c_busy) begin
          state_d = ST_IDLE;
          if (cmd_is_read) begin
            rdata_d  = c_rdata;
            rvalid_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cmd_q      <= '0;
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
      overflow_q <= 1'b0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
      overflow_q <= overflow_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
    end
  end

  // Address/data come straight from the command register, so they hold after issue.
  assign c_haddr     = cmd_q[ENTRY_W-2 -: HADDR_WIDTH];
  assign c_wdata     = cmd_q[DATA_WIDTH-1:0];
  assign c_rd_enable = (state_q == ST_ISSUE) &  cmd_is_read;
  assign c_wr_enable = (state_q == ST_ISSUE) & ~cmd_is_read;

  assign h_full   = fifo_full;
  assign h_rdata  = rdata_q;
  assign h_rvalid = rvalid_q;
  assign overflow = overflow_q;
  assign timeout  = timeout_q;

endmodule
`default_nettype wire

// File: doc/sdram_cmd_queue.md
Name: sdram_cmd_queue

Overview:
- Command buffer between the board-level button/DIP front end and the SDRAM controller.
- Accepts single-cycle read/write request pulses with address and data, queues them, and issues them to the controller one at a time using the controller's busy handshake.
- Captures read data when the controller finishes and returns it with a one-cycle valid strobe.
- Decouples front-end request timing from controller busy periods; requests are never lost silently.

Parameters:
- HADDR_WIDTH, 24, host/controller address width.
- DATA_WIDTH, 16, data word width.
- DEPTH_LOG2, 2, queue depth = 2**DEPTH_LOG2 entries.
- ACK_TIMEOUT, 15, max cycles to wait for c_busy to rise after issue (4-bit counter sized by $clog2(ACK_TIMEOUT+1)).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- h_haddr  in  HADDR_WIDTH  request address, sampled with an enable
- h_wdata  in  DATA_WIDTH  write data, sampled with h_wr_enable
- h_rd_enable  in  1  read request pulse
- h_wr_enable  in  1  write request pulse
- h_full  out  1  queue full; requests this cycle are dropped
- h_rdata  out  DATA_WIDTH  last read data
- h_rvalid  out  1  one-cycle strobe, h_rdata is new
- level  out  DEPTH_LOG2+1  queue occupancy
- overflow  out  1  sticky: a request was dropped
- timeout  out  1  sticky: controller never raised busy after an issue
- c_haddr  out  HADDR_WIDTH  controller address
- c_wdata  out  DATA_WIDTH  controller write data
- c_rd_enable  out  1  controller read pulse
- c_wr_enable  out  1  controller write pulse
- c_busy  in  1  controller busy
- c_rdata  in  DATA_WIDTH  controller read data, valid when busy falls after a read

Behaviour:
- Reset (rst_n low at posedge): all outputs 0, level 0, FIFO pointers 0, FSM in IDLE, sticky flags cleared. Reset mid-operation abandons the in-flight command; no h_rvalid follows.
- Entry format: {is_read, addr, data}. A read entry stores data as 0.
- Push rules:
  - h_wr_enable pushes a write entry.
  - h_rd_enable alone pushes a read entry.
  - Both high in the same cycle: the write is pushed, the read is dropped, overflow is set.
  - Push is accepted only if the queue is not full at the start of the cycle. There is no same-cycle pop bypass, so a push while full is dropped and sets overflow even if a pop occurs that cycle.
- Pointers wrap modulo 2**DEPTH_LOG2. level = push - pop each cycle; range 0..2**DEPTH_LOG2. h_full is (level == 2**DEPTH_LOG2), registered.
- FSM states:
  - IDLE: if not empty and c_busy==0, pop the head into the command register and go to ISSUE.
  - ISSUE (1 cycle): drive c_rd_enable or c_wr_enable high for exactly one cycle, with c_haddr/c_wdata from the command register. Go to WAIT_ACK and clear the timeout counter.
  - WAIT_ACK: on c_busy==1, go to WAIT_DONE. Otherwise increment the counter. When the counter reaches ACK_TIMEOUT, set timeout and go to IDLE; no read data is returned.
  - WAIT_DONE: on c_busy==0, go to IDLE. If the command was a read, register h_rdata <= c_rdata that cycle and pulse h_rvalid the next cycle.
- c_haddr and c_wdata hold their last issued values outside ISSUE. The enables are 0 in every state except ISSUE.
- Issue latency from an empty queue with c_busy low:
  - push at cycle N;
  - pop at N+1 (IDLE);
  - enable at N+2.
- Back-to-back: the next command may leave IDLE in the cycle after WAIT_DONE exits.
- h_rdata holds its value between reads.

Decomposition:
- Shared package: FSM state encoding (IDLE, ISSUE, WAIT_ACK, WAIT_DONE) and the entry width constant (1+HADDR_WIDTH+DATA_WIDTH).
- One sub-module, sync_fifo: parameterized width/depth; push, pop, dout, level, full, empty. The top holds the FSM, drop logic, and read capture.

Test Plan:
- Single write, addr 0x000005, data 0xA5A5, controller model busy 4 cycles starting 1 cycle after enable -> c_wr_enable high exactly 2 cycles after push with matching addr/data; no h_rvalid.
- Single read, addr 0x000123, model returns c_rdata 0x3C3C when busy falls -> h_rdata = 0x3C3C, h_rvalid one cycle, exactly 1 cycle after busy deasserts.
- Push 5 requests back-to-back with depth 4 while the controller is held busy -> h_full high after 4 pushes, 5th dropped, overflow = 1, level = 4; then 4 issues in push order.
- h_rd_enable and h_wr_enable high in the same cycle -> only the write is queued and issued, overflow = 1.
- Controller model never raises busy -> timeout = 1 after ACK_TIMEOUT cycles in WAIT_ACK, FSM returns to IDLE, next queued command issues.
- rst_n low during WAIT_DONE of a read -> all outputs 0 next cycle, level 0, no h_rvalid after reset release.
